// File: rtl/div_restoring_if.sv
// Request/response bundle between the CPU control unit and the divider.
interface div_restoring_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor_in;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             fim;
   logic             div_zero;
   logic             busy;

   // control unit side
   modport master (
      output start, dividend, divisor_in,
      input  quotient, remainder, fim, div_zero, busy
   );

   // divider side
   modport slave (
      input  start, dividend, divisor_in,
      output quotient, remainder, fim, div_zero, busy
   );
endinterface

// File: rtl/div_restoring.sv
// Sequential signed restoring divider: one shift/trial-subtract step per clock,
// fixed latency, quotient truncated toward zero, remainder takes dividend sign.
module div_restoring #(
   parameter int WIDTH = 32
) (
   input  logic          clock,
   input  logic          reset,
   div_restoring_if.slave bus
);
   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t           state;
   logic [WIDTH:0]   rem;      // partial remainder, one guard bit
   logic [WIDTH-1:0] q_sh;     // dividend magnitude shifting out, quotient shifting in
   logic [WIDTH-1:0] dvs;      // divisor magnitude
   logic             neg_q;
   logic             neg_r;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] rem_q;
   logic             fim_q;
   logic             dz_q;
   logic             busy_q;

   // Magnitudes are formed in WIDTH+1 bits so the most negative operand is exact.
   logic [WIDTH:0]   a_ext, b_ext, abs_a, abs_b;
   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] trial;

   // operand magnitudes and the trial subtraction for the current step
   always_comb begin
      a_ext   = {bus.dividend[WIDTH-1], bus.dividend};
      b_ext   = {bus.divisor_in[WIDTH-1], bus.divisor_in};
      abs_a   = bus.dividend[WIDTH-1]   ? -a_ext : a_ext;
      abs_b   = bus.divisor_in[WIDTH-1] ? -b_ext : b_ext;
      shifted = {rem[WIDTH-1:0], q_sh[WIDTH-1]};
      trial   = {1'b0, shifted} - {2'b00, dvs};
   end

   // control FSM with datapath and registered outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         rem    <= '0;
         q_sh   <= '0;
         dvs    <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         cnt    <= '0;
         quo_q  <= '0;
         rem_q  <= '0;
         fim_q  <= 1'b0;
         dz_q   <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         fim_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  busy_q <= 1'b1;
                  dz_q   <= 1'b0;
                  if (bus.divisor_in == '0) begin
                     // results from the previous division are left untouched
                     dz_q  <= 1'b1;
                     fim_q <= 1'b1;
                     state <= DONE;
                  end else begin
                     q_sh  <= abs_a[WIDTH-1:0];
                     dvs   <= abs_b[WIDTH-1:0];
                     rem   <= '0;
                     neg_q <= bus.dividend[WIDTH-1] ^ bus.divisor_in[WIDTH-1];
                     neg_r <= bus.dividend[WIDTH-1];
                     cnt   <= '0;
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (!trial[WIDTH+1]) begin
                  rem  <= trial[WIDTH:0];
                  q_sh <= {q_sh[WIDTH-2:0], 1'b1};
               end else begin
                  rem  <= shifted;
                  q_sh <= {q_sh[WIDTH-2:0], 1'b0};
               end
               cnt <= cnt + 1'b1;
               if (cnt == LAST) state <= FIX;
            end
            FIX: begin
               quo_q <= neg_q ? -q_sh : q_sh;
               rem_q <= neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
               fim_q <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.quotient  = quo_q;
   assign bus.remainder = rem_q;
   assign bus.fim       = fim_q;
   assign bus.div_zero  = dz_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_div_restoring.sv
// Self-checking bench for div_restoring: directed corner cases plus random
// operands against a plain-arithmetic signed division model.
module tb_div_restoring;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   div_restoring_if #(.WIDTH(32)) ifc ();

   div_restoring #(.WIDTH(32)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (ifc.slave)
   );

   always #5 clk = ~clk;

   // reference: 64-bit signed arithmetic truncates toward zero, % follows dividend sign
   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
   endfunction

   // issue one request and wait for fim; operands are scrambled after the start edge
   task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] q, output logic [31:0] r,
                          output logic dz, output logic busy_ok, output logic busy_after);
      @(negedge clk);
      ifc.dividend = a; ifc.divisor_in = b; ifc.start = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0; ifc.dividend = $urandom; ifc.divisor_in = $urandom;
      lat = 0; busy_ok = 1'b1;
      while (!ifc.fim && lat < 100) begin
         if (!ifc.busy) busy_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      if (!ifc.busy) busy_ok = 1'b0;
      q = ifc.quotient; r = ifc.remainder; dz = ifc.div_zero;
      @(negedge clk);
      busy_after = ifc.busy;
      if (ifc.fim) busy_ok = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      checks++;
      if ({ifc.quotient, ifc.remainder, ifc.fim, ifc.div_zero, ifc.busy} !== 67'd0) begin
         failures++;
         $display("FAIL reset_outputs got q=%h r=%h fim=%b dz=%b busy=%b want all 0",
                  ifc.quotient, ifc.remainder, ifc.fim, ifc.div_zero, ifc.busy);
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic check_div(input string name, input logic [31:0] a, input logic [31:0] b);
      int lat; logic [31:0] q, r, eq, er; logic dz, bok, baft;
      model(a, b, eq, er);
      run_div(a, b, lat, q, r, dz, bok, baft);
      checks++;
      if (q !== eq || r !== er || dz !== 1'b0) begin
         failures++;
         $display("FAIL %s result got q=%h r=%h dz=%b want q=%h r=%h dz=0", name, q, r, dz, eq, er);
      end
      checks++;
      if (lat !== 33) begin
         failures++;
         $display("FAIL %s latency got %0d edges after start want 33", name, lat);
      end
      checks++;
      if (bok !== 1'b1 || baft !== 1'b0) begin
         failures++;
         $display("FAIL %s busy got during=%b after=%b want 1 0", name, bok, baft);
      end
   endtask

   task automatic test_directed();
      check_div("100_div_7",   32'd100,        32'd7);
      check_div("m7_div_2",    32'hFFFFFFF9,   32'd2);
      check_div("7_div_m2",    32'd7,          32'hFFFFFFFE);
      check_div("min_div_m1",  32'h80000000,   32'hFFFFFFFF);
      check_div("min_div_1",   32'h80000000,   32'd1);
      check_div("min_div_min", 32'h80000000,   32'h80000000);
      check_div("small_big",   32'd3,          32'h7FFFFFFF);
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++) begin
         logic [31:0] a, b;
         a = $urandom;
         if (i % 3 == 0) a = 32'($urandom_range(0, 1000)) * (((i & 2) != 0) ? -1 : 1);
         b = (i % 2 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
         if ((i & 4) != 0) b = -b;
         if (b == 32'd0) b = 32'd1;
         check_div($sformatf("rand%0d", i), a, b);
      end
   endtask

   task automatic test_div_zero();
      int lat; logic [31:0] q, r; logic dz, bok, baft;
      check_div("dz_pre_100_7", 32'd100, 32'd7);
      run_div(32'd5, 32'd0, lat, q, r, dz, bok, baft);
      checks++;
      if (lat !== 0 || dz !== 1'b1) begin
         failures++;
         $display("FAIL div_zero_flag got lat=%0d dz=%b want lat=0 dz=1", lat, dz);
      end
      checks++;
      if (q !== 32'd14 || r !== 32'd2) begin
         failures++;
         $display("FAIL div_zero_hold got q=%h r=%h want q=0000000e r=00000002", q, r);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (ifc.div_zero !== 1'b1 || ifc.busy !== 1'b0) begin
         failures++;
         $display("FAIL div_zero_sticky got dz=%b busy=%b want dz=1 busy=0", ifc.div_zero, ifc.busy);
      end
      check_div("dz_post_9_3", 32'd9, 32'd3);
   endtask

   task automatic test_start_busy();
      int nf = 0, fk = -1; logic [31:0] q = '0, r = '0;
      @(negedge clk);
      ifc.dividend = 32'd100; ifc.divisor_in = 32'd7; ifc.start = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 45; k++) begin
         if (ifc.fim) begin nf++; fk = k; q = ifc.quotient; r = ifc.remainder; end
         ifc.start = (k == 5 || k == 20);
         ifc.dividend = 32'd1234 + 32'(k); ifc.divisor_in = 32'd3;
         @(negedge clk);
      end
      ifc.start = 1'b0;
      checks++;
      if (nf !== 1 || fk !== 33) begin
         failures++;
         $display("FAIL start_busy_fim got count=%0d at=%0d want count=1 at=33", nf, fk);
      end
      checks++;
      if (q !== 32'd14 || r !== 32'd2) begin
         failures++;
         $display("FAIL start_busy_result got q=%h r=%h want 0000000e 00000002", q, r);
      end
   endtask

   task automatic test_reset_mid();
      int nf = 0;
      @(negedge clk);
      ifc.dividend = 32'd100; ifc.divisor_in = 32'd7; ifc.start = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({ifc.quotient, ifc.remainder, ifc.fim, ifc.div_zero, ifc.busy} !== 67'd0) begin
         failures++;
         $display("FAIL reset_mid_outputs got q=%h r=%h fim=%b dz=%b busy=%b want all 0",
                  ifc.quotient, ifc.remainder, ifc.fim, ifc.div_zero, ifc.busy);
      end
      @(negedge clk); rst = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (ifc.fim || ifc.busy) nf++;
         @(negedge clk);
      end
      checks++;
      if (nf !== 0) begin
         failures++;
         $display("FAIL reset_mid_no_fim got %0d active cycles want 0", nf);
      end
      check_div("post_reset_50_5", 32'd50, 32'd5);
   endtask

   initial begin
      ifc.start = 1'b0; ifc.dividend = '0; ifc.divisor_in = '0;
      test_reset();
      test_directed();
      test_div_zero();
      test_start_busy();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
